vreg_xfer_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the 8x16x16 vector register file.

---
 rtl/vreg_xfer_ctrl_if.sv | 48 ++++
 rtl/vreg_xfer_ctrl.sv | 141 ++++++++++++++
 tb/tb_vreg_xfer_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vreg_xfer_ctrl_if.sv
// rtl/vreg_xfer_ctrl_if.sv - requester and register-file signal bundle for vreg_xfer_ctrl
interface vreg_xfer_ctrl_if #(
    parameter int VLEN = 16,
    parameter int DW   = 16,
    parameter int AW   = 3,
    parameter int EW   = $clog2(VLEN)
);
    // requester 0 (execute unit)
    logic          Req0_v;
    logic          Req0_wr;
    logic [AW-1:0] Req0_addr;
    logic [AW-1:0] Req0_addr2;
    logic [DW-1:0] Req0_wdata;
    logic          Gnt0;
    // requester 1 (load/store unit)
    logic          Req1_v;
    logic          Req1_wr;
    logic [AW-1:0] Req1_addr;
    logic [AW-1:0] Req1_addr2;
    logic [DW-1:0] Req1_wdata;
    logic          Gnt1;
    // register-file side and status
    logic          RD_s;
    logic          WR_s;
    logic [AW-1:0] Addr;
    logic [AW-1:0] Addr2;
    logic [DW-1:0] DataIn_s;
    logic [EW-1:0] Elem;
    logic          RdValid;
    logic [EW-1:0] RdElem;
    logic          Owner;
    logic          Busy;
    logic          Done;

    modport master (
        output Req0_v, Req0_wr, Req0_addr, Req0_addr2, Req0_wdata,
        output Req1_v, Req1_wr, Req1_addr, Req1_addr2, Req1_wdata,
        input  Gnt0, Gnt1, RD_s, WR_s, Addr, Addr2, DataIn_s,
        input  Elem, RdValid, RdElem, Owner, Busy, Done
    );

    modport slave (
        input  Req0_v, Req0_wr, Req0_addr, Req0_addr2, Req0_wdata,
        input  Req1_v, Req1_wr, Req1_addr, Req1_addr2, Req1_wdata,
        output Gnt0, Gnt1, RD_s, WR_s, Addr, Addr2, DataIn_s,
        output Elem, RdValid, RdElem, Owner, Busy, Done
    );
endinterface

// File: rtl/vreg_xfer_ctrl.sv
// rtl/vreg_xfer_ctrl.sv - round-robin whole-vector transfer sequencer for the vector register file
module vreg_xfer_ctrl #(
    parameter int VLEN = 16,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input logic              Clk1,
    input logic              Rst,
    vreg_xfer_ctrl_if.slave  bus
);
    localparam int EW = $clog2(VLEN);
    localparam logic [EW-1:0] LAST_ELEM = EW'(VLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] addr2_q, addr2_d;
    logic [EW-1:0] elem_q, elem_d;
    // prio_q names the requester that wins a tie, i.e. the one not served last
    logic          prio_q, prio_d;
    logic          rdvalid_q, rdvalid_d;
    logic [EW-1:0] rdelem_q, rdelem_d;

    logic any_req;
    logic win;
    logic rd_s;

    // arbitration: a lone requester wins, a tie goes to the priority holder
    always_comb begin
        any_req = bus.Req0_v | bus.Req1_v;
        win     = bus.Req1_v & (~bus.Req0_v | prio_q);
    end

    // state register
    always_ff @(posedge Clk1) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: one transfer is VLEN strobe cycles followed by a single turnaround cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_XFER;
            S_XFER:  if (elem_q == LAST_ELEM) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // transfer context registers; reset also drops any partial transfer
    always_ff @(posedge Clk1) begin
        if (Rst) begin
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            addr2_q   <= '0;
            elem_q    <= '0;
            prio_q    <= 1'b0;
            rdvalid_q <= 1'b0;
            rdelem_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            addr2_q   <= addr2_d;
            elem_q    <= elem_d;
            prio_q    <= prio_d;
            rdvalid_q <= rdvalid_d;
            rdelem_q  <= rdelem_d;
        end
    end

    // context next values: latch the winner in IDLE, step the element in XFER, rotate priority in GAP
    always_comb begin
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        addr2_d   = addr2_q;
        elem_d    = elem_q;
        prio_d    = prio_q;
        // register file returns read data one cycle after the strobe
        rdvalid_d = rd_s;
        rdelem_d  = elem_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    wr_d    = win ? bus.Req1_wr   : bus.Req0_wr;
                    addr_d  = win ? bus.Req1_addr : bus.Req0_addr;
                    // a write only uses the primary port, so mirror it onto the second address
                    if (win ? bus.Req1_wr : bus.Req0_wr) begin
                        addr2_d = win ? bus.Req1_addr : bus.Req0_addr;
                    end else begin
                        addr2_d = win ? bus.Req1_addr2 : bus.Req0_addr2;
                    end
                    elem_d  = '0;
                end
            end
            S_XFER: begin
                elem_d = (elem_q == LAST_ELEM) ? '0 : elem_q + EW'(1);
            end
            S_GAP: begin
                prio_d = ~owner_q;
            end
            default: ;
        endcase
    end

    // outputs: strobes, grant and status decode directly from state and context
    always_comb begin
        rd_s         = (state_q == S_XFER) & ~wr_q;
        bus.RD_s     = rd_s;
        bus.WR_s     = (state_q == S_XFER) & wr_q;
        // the first XFER cycle is the only one with elem 0, so it doubles as the grant pulse
        bus.Gnt0     = (state_q == S_XFER) && (elem_q == '0) && !owner_q;
        bus.Gnt1     = (state_q == S_XFER) && (elem_q == '0) && owner_q;
        bus.Done     = (state_q == S_GAP);
        bus.Busy     = (state_q != S_IDLE);
        bus.Addr     = addr_q;
        bus.Addr2    = addr2_q;
        bus.Elem     = elem_q;
        bus.Owner    = owner_q;
        bus.RdValid  = rdvalid_q;
        bus.RdElem   = rdelem_q;
        bus.DataIn_s = '0;
        if ((state_q == S_XFER) && wr_q) begin
            bus.DataIn_s = owner_q ? bus.Req1_wdata : bus.Req0_wdata;
        end
    end
endmodule

// File: tb/tb_vreg_xfer_ctrl.sv
// tb/tb_vreg_xfer_ctrl.sv - directed self-checking bench for vreg_xfer_ctrl
module tb_vreg_xfer_ctrl;
    logic Clk1 = 1'b0;
    logic Rst  = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   waited;
    logic [15:0] wbase0 = 16'h0;
    logic [15:0] wbase1 = 16'h0;

    vreg_xfer_ctrl_if #(.VLEN(16), .DW(16), .AW(3)) bus ();

    vreg_xfer_ctrl #(.VLEN(16), .DW(16), .AW(3)) dut (
        .Clk1 (Clk1),
        .Rst  (Rst),
        .bus  (bus.slave)
    );

    always #5 Clk1 = ~Clk1;

    assign bus.Req0_wdata = wbase0 + 16'(bus.Elem);
    assign bus.Req1_wdata = wbase1 + 16'(bus.Elem);

    // register file model: write on strobe, registered dual read port
    logic [15:0] mem [8][16];
    logic [15:0] dout, dout2;
    always @(posedge Clk1) begin
        if (bus.WR_s) mem[bus.Addr][bus.Elem] <= bus.DataIn_s;
        dout  <= mem[bus.Addr][bus.Elem];
        dout2 <= mem[bus.Addr2][bus.Elem];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk1);
    endtask

    task automatic set_v(input int req, input logic val);
        if (req == 0) bus.Req0_v = val;
        else if (req == 1) bus.Req1_v = val;
    endtask

    task automatic run_xfer(input bit exp_owner, input bit exp_wr, input logic [2:0] exp_addr,
                            input logic [2:0] exp_addr2, input logic [15:0] base, input bit hold,
                            input int pulse_req, input int pulse_at, input int pulse_len,
                            input int rst_at, output int nwait);
        nwait = 0;
        while (!(bus.Gnt0 || bus.Gnt1) && nwait < 40) begin
            step();
            nwait++;
        end
        chk("grant_seen", 32'(bus.Gnt0 | bus.Gnt1), 1);
        if (!(bus.Gnt0 || bus.Gnt1)) return;
        if (!hold) set_v(exp_owner ? 1 : 0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk("grant", {bus.Gnt1, bus.Gnt0}, (k == 0) ? (exp_owner ? 2 : 1) : 0);
            chk("owner", bus.Owner, exp_owner);
            chk("rd_s", bus.RD_s, !exp_wr);
            chk("wr_s", bus.WR_s, exp_wr);
            chk("addr", bus.Addr, exp_addr);
            chk("addr2", bus.Addr2, exp_wr ? exp_addr : exp_addr2);
            chk("elem", bus.Elem, k);
            chk("busy", bus.Busy, 1);
            chk("done", bus.Done, 0);
            chk("rdvalid", bus.RdValid, !exp_wr && k > 0);
            if (exp_wr) chk("datain", bus.DataIn_s, base + 16'(k));
            if (!exp_wr && k > 0) begin
                chk("rdelem", bus.RdElem, k - 1);
                chk("dout", dout, base + 16'(k - 1));
                chk("dout2", dout2, base + 16'(k - 1));
            end
            if (pulse_req >= 0 && k == pulse_at) set_v(pulse_req, 1'b1);
            if (pulse_req >= 0 && k == pulse_at + pulse_len) set_v(pulse_req, 1'b0);
            if (k == rst_at) begin
                Rst = 1'b1;
                step();
                chk("rst_strobe", {bus.RD_s, bus.WR_s}, 0);
                chk("rst_busy", bus.Busy, 0);
                chk("rst_done", bus.Done, 0);
                chk("rst_rdvalid", bus.RdValid, 0);
                chk("rst_elem", bus.Elem, 0);
                Rst = 1'b0;
                step();
                chk("post_rst_done", bus.Done, 0);
                chk("post_rst_rdvalid", bus.RdValid, 0);
                return;
            end
            step();
        end
        chk("gap_strobe", {bus.RD_s, bus.WR_s}, 0);
        chk("gap_done", bus.Done, 1);
        chk("gap_busy", bus.Busy, 1);
        chk("gap_grant", {bus.Gnt1, bus.Gnt0}, 0);
        chk("gap_rdvalid", bus.RdValid, !exp_wr);
        if (!exp_wr) begin
            chk("gap_rdelem", bus.RdElem, 15);
            chk("gap_dout", dout, base + 16'd15);
            chk("gap_dout2", dout2, base + 16'd15);
        end
        step();
        chk("idle_strobe", {bus.RD_s, bus.WR_s}, 0);
        chk("idle_done", bus.Done, 0);
        chk("idle_busy", bus.Busy, 0);
        chk("idle_rdvalid", bus.RdValid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Req0_v = 0; bus.Req0_wr = 0; bus.Req0_addr = 0; bus.Req0_addr2 = 0;
        bus.Req1_v = 0; bus.Req1_wr = 0; bus.Req1_addr = 0; bus.Req1_addr2 = 0;
        Rst = 1'b1;
        step();
        step();
        chk("rst_strobes", {bus.RD_s, bus.WR_s, bus.Gnt1, bus.Gnt0, bus.Done, bus.RdValid, bus.Busy}, 0);
        chk("rst_elem", {bus.Elem, bus.RdElem}, 0);
        chk("rst_owner_addr", {bus.Owner, bus.Addr, bus.Addr2}, 0);
        chk("rst_datain", bus.DataIn_s, 0);

        // 1: requester 0 writes vector 2 with A000+k; Addr2 must mirror Addr
        Rst = 1'b0;
        wbase0 = 16'hA000;
        bus.Req0_v = 1; bus.Req0_wr = 1; bus.Req0_addr = 3'd2; bus.Req0_addr2 = 3'd5;
        run_xfer(0, 1, 3'd2, 3'd5, 16'hA000, 0, -1, 0, 0, -1, waited);
        chk("t1_latency", waited, 1);
        for (int k = 0; k < 16; k++) chk("t1_mem", mem[2][k], 16'hA000 + 16'(k));

        // 2: requester 1 reads vector 2 on both ports
        bus.Req1_v = 1; bus.Req1_wr = 0; bus.Req1_addr = 3'd2; bus.Req1_addr2 = 3'd2;
        run_xfer(1, 0, 3'd2, 3'd2, 16'hA000, 0, -1, 0, 0, -1, waited);
        chk("t2_latency", waited, 1);

        // 3: both held after reset -> 0,1,0,1
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        wbase0 = 16'hD000;
        bus.Req0_v = 1; bus.Req0_wr = 1; bus.Req0_addr = 3'd4;
        bus.Req1_v = 1; bus.Req1_wr = 0; bus.Req1_addr = 3'd2; bus.Req1_addr2 = 3'd2;
        run_xfer(0, 1, 3'd4, 3'd4, 16'hD000, 1, -1, 0, 0, -1, waited);
        run_xfer(1, 0, 3'd2, 3'd2, 16'hA000, 1, -1, 0, 0, -1, waited);
        chk("t3_turnaround", waited, 1);
        run_xfer(0, 1, 3'd4, 3'd4, 16'hD000, 1, -1, 0, 0, -1, waited);
        run_xfer(1, 0, 3'd2, 3'd2, 16'hA000, 1, -1, 0, 0, -1, waited);
        bus.Req0_v = 0; bus.Req1_v = 0;

        // 4: requester 1 raised mid-transfer waits for the IDLE after Done
        wbase0 = 16'hC000;
        bus.Req0_v = 1; bus.Req0_wr = 1; bus.Req0_addr = 3'd5;
        bus.Req1_wr = 0; bus.Req1_addr = 3'd5; bus.Req1_addr2 = 3'd5;
        run_xfer(0, 1, 3'd5, 3'd5, 16'hC000, 0, 1, 3, 100, -1, waited);
        chk("t4_no_early_gnt1", bus.Gnt1, 0);
        run_xfer(1, 0, 3'd5, 3'd5, 16'hC000, 0, -1, 0, 0, -1, waited);
        chk("t4_turnaround", waited, 1);

        // 5: reset lands on the edge that would have started element 7
        wbase0 = 16'hB000;
        bus.Req0_v = 1; bus.Req0_wr = 1; bus.Req0_addr = 3'd2;
        run_xfer(0, 1, 3'd2, 3'd2, 16'hB000, 0, -1, 0, 0, 6, waited);
        for (int k = 0; k < 16; k++)
            chk("t5_mem", mem[2][k], (k < 7) ? 16'hB000 + 16'(k) : 16'hA000 + 16'(k));

        // 6: one-cycle Req0 pulse during requester 1 transfer is never granted
        bus.Req1_v = 1; bus.Req1_wr = 0; bus.Req1_addr = 3'd5; bus.Req1_addr2 = 3'd5;
        run_xfer(1, 0, 3'd5, 3'd5, 16'hC000, 0, 0, 4, 1, -1, waited);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_gnt0", bus.Gnt0, 0);
            chk("t6_idle", bus.Busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
